// File: rtl/keypad_time_entry.sv
// keypad_time_entry: keypad front end for the microwave timer.
// Debounces one-hot keypad presses into an M:SS BCD shift buffer, then on start
// pulses an active-low load into the timer_ten chain and enables counting until
// the chain reports it has finished (busy falls) or the user cancels.
// Ports:
//   clk, clr                   rising-edge clock, synchronous active-high reset
//   keys[9:0]                  raw keypad levels, bit n = digit n
//   start, cancel              level requests
//   busy                       timer chain running
//   min_ones/sec_tens/sec_ones BCD digits to the timer chain
//   loadn, run                 load strobe (active low) and count enable
//   entry_cnt[1:0]             digits accepted so far
module keypad_time_entry #(
  parameter int unsigned LOAD_CYCLES  = 2,
  parameter int unsigned SEC_TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [9:0] keys,
  input  logic       start,
  input  logic       cancel,
  input  logic       busy,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       loadn,
  output logic       run,
  output logic [1:0] entry_cnt
);

  localparam int unsigned CTR_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ENTRY = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;
  localparam logic [1:0] RUN   = 2'd3;

  logic [1:0]       state, state_d;
  logic [9:0]       keys_q;
  logic             busy_q;
  logic [CTR_W-1:0] load_ctr, load_ctr_d;
  logic [3:0]       min_ones_d, sec_tens_d, sec_ones_d;
  logic             loadn_d, run_d;
  logic [1:0]       entry_cnt_d;
  logic [3:0]       code;
  logic             accept;

  // Encode the pressed digit; a press counts only from a fully released pad.
  always_comb begin
    code = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (keys[i]) code = code | 4'(i);
    end
    accept = $onehot(keys) && (keys_q == '0);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    min_ones_d  = min_ones;
    sec_tens_d  = sec_tens;
    sec_ones_d  = sec_ones;
    entry_cnt_d = entry_cnt;
    load_ctr_d  = load_ctr;
    loadn_d     = 1'b1;
    run_d       = 1'b0;
    case (state)
      IDLE: begin
        min_ones_d  = 4'd0;
        sec_tens_d  = 4'd0;
        sec_ones_d  = 4'd0;
        entry_cnt_d = 2'd0;
        if (accept) begin
          sec_ones_d  = code;
          entry_cnt_d = 2'd1;
          state_d     = ENTRY;
        end
      end
      ENTRY: begin
        if (cancel) begin
          min_ones_d  = 4'd0;
          sec_tens_d  = 4'd0;
          sec_ones_d  = 4'd0;
          entry_cnt_d = 2'd0;
          state_d     = IDLE;
        end else if (start) begin
          // Start wins over a same-cycle key; clamp an illegal tens digit now.
          state_d    = LOAD;
          loadn_d    = 1'b0;
          load_ctr_d = CTR_W'(LOAD_CYCLES - 1);
          if (sec_tens > 4'(SEC_TENS_MAX)) sec_tens_d = 4'(SEC_TENS_MAX);
        end else if (accept && (entry_cnt != 2'd3)) begin
          min_ones_d  = sec_tens;
          sec_tens_d  = sec_ones;
          sec_ones_d  = code;
          entry_cnt_d = entry_cnt + 2'd1;
        end
      end
      LOAD: begin
        loadn_d = 1'b0;
        if (load_ctr == '0) begin
          loadn_d = 1'b1;
          run_d   = 1'b1;
          state_d = RUN;
        end else begin
          load_ctr_d = load_ctr - CTR_W'(1);
        end
      end
      RUN: begin
        run_d = 1'b1;
        if (cancel || (busy_q && !busy)) begin
          run_d       = 1'b0;
          min_ones_d  = 4'd0;
          sec_tens_d  = 4'd0;
          sec_ones_d  = 4'd0;
          entry_cnt_d = 2'd0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_d;
  end

  // Registered outputs and input history.
  always_ff @(posedge clk) begin
    if (clr) begin
      keys_q    <= '0;
      busy_q    <= 1'b0;
      load_ctr  <= '0;
      min_ones  <= 4'd0;
      sec_tens  <= 4'd0;
      sec_ones  <= 4'd0;
      entry_cnt <= 2'd0;
      loadn     <= 1'b1;
      run       <= 1'b0;
    end else begin
      keys_q    <= keys;
      busy_q    <= busy;
      load_ctr  <= load_ctr_d;
      min_ones  <= min_ones_d;
      sec_tens  <= sec_tens_d;
      sec_ones  <= sec_ones_d;
      entry_cnt <= entry_cnt_d;
      loadn     <= loadn_d;
      run       <= run_d;
    end
  end

endmodule

// File: tb/tb_keypad_time_entry.sv
// Directed bench for keypad_time_entry: key entry, lockout, clamp, load strobe
// width, run termination and reset from mid-load.
module tb_keypad_time_entry;

  logic       clk = 1'b0;
  logic       clr, start, cancel, busy;
  logic [9:0] keys;
  logic [3:0] min_ones, sec_tens, sec_ones;
  logic       loadn, run;
  logic [1:0] entry_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  keypad_time_entry #(.LOAD_CYCLES(2), .SEC_TENS_MAX(5)) dut (
    .clk(clk), .clr(clr), .keys(keys), .start(start), .cancel(cancel),
    .busy(busy), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .loadn(loadn), .run(run), .entry_cnt(entry_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int d, input int hold, input int rel);
    keys = 10'(1) << d;
    repeat (hold) tick();
    keys = '0;
    repeat (rel) tick();
  endtask

  function automatic logic [15:0] digits();
    return {4'h0, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic do_reset();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  int lows;
  int waited;

  initial begin
    clr = 1'b1; keys = '0; start = 1'b0; cancel = 1'b0; busy = 1'b0;
    tick(); tick();
    clr = 1'b0;
    check("rst_digits", digits(), 16'h0000);
    check("rst_cnt", 16'(entry_cnt), 16'd0);
    check("rst_loadn", 16'(loadn), 16'd1);
    check("rst_run", 16'(run), 16'd0);

    // Three digits shift in as M:SS.
    press(1, 3, 2);
    check("t1_first", digits(), 16'h0001);
    press(3, 3, 2);
    press(0, 3, 2);
    check("t1_digits", digits(), 16'h0130);
    check("t1_cnt", 16'(entry_cnt), 16'd3);

    // Fourth digit is ignored.
    press(7, 3, 2);
    check("t2_digits", digits(), 16'h0130);
    check("t2_cnt", 16'(entry_cnt), 16'd3);

    // Multi-key never accepts; a held key accepts once.
    do_reset();
    keys = 10'b0000000110;
    repeat (4) tick();
    check("t3_multi_cnt", 16'(entry_cnt), 16'd0);
    keys = '0;
    repeat (2) tick();
    press(5, 6, 2);
    check("t3_hold_cnt", 16'(entry_cnt), 16'd1);
    check("t3_hold_dig", digits(), 16'h0005);

    // Cancel beats start; start alone in IDLE does nothing.
    cancel = 1'b1; start = 1'b1;
    tick();
    cancel = 1'b0; start = 1'b0;
    check("cancel_start_cnt", 16'(entry_cnt), 16'd0);
    check("cancel_start_dig", digits(), 16'h0000);
    check("cancel_start_loadn", 16'(loadn), 16'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("idle_start_loadn", 16'(loadn), 16'd1);

    // Clamp, start beats a same-cycle key, loadn low for two cycles.
    press(2, 2, 2);
    press(8, 2, 2);
    press(5, 2, 2);
    check("t4_entry", digits(), 16'h0285);
    start = 1'b1; keys = 10'h200;
    tick();
    start = 1'b0;
    check("t4_loadn0", 16'(loadn), 16'd0);
    check("t4_clamp", digits(), 16'h0255);
    check("t4_run_in_load", 16'(run), 16'd0);
    keys = '0;
    lows = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (loadn == 1'b0) lows++;
      else break;
    end
    check("t4_load_width", 16'(lows), 16'd2);
    check("t4_run", 16'(run), 16'd1);
    check("t4_run_dig", digits(), 16'h0255);

    // Busy falling edge ends the run.
    busy = 1'b1;
    press(4, 2, 2);
    repeat (16) tick();
    check("t5_run_hold", 16'(run), 16'd1);
    check("t5_dig_hold", digits(), 16'h0255);
    busy = 1'b0;
    tick();
    check("t5_done_run", 16'(run), 16'd0);
    check("t5_done_dig", digits(), 16'h0000);
    check("t5_done_cnt", 16'(entry_cnt), 16'd0);

    // Cancel during the run.
    press(1, 2, 2);
    press(2, 2, 2);
    press(3, 2, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    waited = 0;
    while (run != 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    check("t5c_run", 16'(run), 16'd1);
    check("t5c_dig", digits(), 16'h0123);
    tick(); tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("t5c_run_off", 16'(run), 16'd0);
    check("t5c_dig_off", digits(), 16'h0000);

    // Reset during the first LOAD cycle.
    press(4, 2, 2);
    press(5, 2, 2);
    press(6, 2, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_in_load", 16'(loadn), 16'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t6_loadn", 16'(loadn), 16'd1);
    check("t6_run", 16'(run), 16'd0);
    check("t6_dig", digits(), 16'h0000);
    check("t6_cnt", 16'(entry_cnt), 16'd0);
    tick();
    check("t6_loadn_after", 16'(loadn), 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
